cpu_mem_ctrl: RTL and testbench
===============================

# cpu_mem_ctrl

Sub-word load/store adapter between the CPU-side Wishbone-style bus and the word-wide block RAM (`mem_bram`). It converts byte, halfword and word accesses with a 3-bit size/extension code into aligned 32-bit memory transactions with a 4-bit byte-enable. On reads, it extracts the addressed lane from the returned memory word and sign- or zero-extends it. It sits behind the bus address decoder, in the memory slave path.

## Interface
- No parameters. Outstanding-request tracking depth is fixed at 2.
- `i_clk` in 1: system clock; all registers on rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_wb_stb` in 1: CPU request strobe, already decoded for the memory range.
- `i_wb_we` in 1: 1 = store, 0 = load.
- `i_wb_addr` in 32: CPU byte address.
- `i_wb_data` in 32: store data, right-justified.
- `i_sel` in 3: access code. 000 = byte signed, 001 = half signed, 010 = word, 100 = byte unsigned, 101 = half unsigned. 011, 110 and 111 are treated as word.
- `o_wb_data` out 32: extended load result to the CPU.
- `o_wb_ack` out 1: response to the CPU.
- `o_wb_stall` out 1: CPU must hold its request.
- `o_wb_stb` out 1: memory request strobe.
- `o_wb_we` out 1: memory write enable.
- `o_wb_addr` out 32: memory byte address, word-aligned.
- `o_mem_wb_data` out 32: lane-replicated store data to memory.
- `o_wb_sel` out 4: memory byte enables; bit n enables bits [8n+7:8n].
- `i_mem_wb_data` in 32: read word from memory.
- `i_wb_ack` in 1: memory ack.
- `i_wb_stall` in 1: memory stall.

## Operation
- Little-endian lane numbering. The offset is `i_wb_addr[1:0]`.
- Request path (combinational):
  - `o_wb_addr` = {`i_wb_addr[31:2]`, 2'b00}.
  - `o_wb_we` = `i_wb_we`.
  - `o_wb_stb` = `i_wb_stb` & !full.
- Byte access:
  - `o_wb_sel` = 4'b0001 << offset.
  - `o_mem_wb_data` = 4 copies of `i_wb_data[7:0]`.
- Half access:
  - `o_wb_sel` = `i_wb_addr[1]` ? 4'b1100 : 4'b0011.
  - `o_mem_wb_data` = 2 copies of `i_wb_data[15:0]`.
  - `i_wb_addr[0]` is ignored; no misalignment trap.
- Word access:
  - `o_wb_sel` = 4'b1111.
  - `o_mem_wb_data` = `i_wb_data`.
  - `i_wb_addr[1:0]` is ignored.
- Stores with unsigned codes behave exactly like the signed codes of the same width.
- Loads drive the same `o_wb_sel` as stores.
- Acceptance: a request is accepted when `i_wb_stb` & !`o_wb_stall`. On acceptance, {`i_sel`, `i_wb_addr[1:0]`} is pushed into a 2-entry FIFO. This applies to reads and writes.
- `o_wb_stall` = `i_wb_stall` | full. Full means count == 2, regardless of a same-cycle pop.
- Response path:
  - `o_wb_ack` = `i_wb_ack` (combinational).
  - When `i_wb_ack` = 1, the FIFO head is popped.
  - `o_wb_data` = `i_mem_wb_data` >> (8 × head offset), then extended per the head code. For half access the effective offset is {head `addr[1]`, 0}.
  - Signed codes replicate bit 7 or bit 15; unsigned codes zero-fill; word passes through.
- On write acks, `o_wb_data` is computed the same way and is don't-care to the CPU.
- Ack with an empty FIFO (spurious): pass `o_wb_ack`, decode data as word, leave count unchanged.
- Push and pop in the same cycle: count unchanged, entry order preserved.

## Timing
- Zero added latency. Request and response are both combinational pass-through; the only state is the FIFO.
- With a 1-cycle BRAM: stb at cycle N, ack at cycle N+1 with extracted data valid in the same cycle.
- Reset, at assertion:
  - FIFO is emptied and count = 0; `o_wb_stall` then equals `i_wb_stall`.
  - Combinational outputs follow their inputs; with idle inputs all outputs are 0 except the lane-derived values.
- Reset mid-transaction: tracked requests are discarded. Memory is reset at the same time, so no stale acks are expected.

## Test plan
- Memory word 0x8899AABB at 0x100. Load byte signed at 0x103 -> `o_wb_sel` 1000, `o_wb_addr` 0x100, `o_wb_data` 0xFFFFFF88. Same access unsigned (100) -> 0x00000088.
- Load half signed at 0x102 -> sel 1100, data 0xFFFF8899. Load half unsigned at 0x100 -> 0x0000AABB. Load word -> 0x8899AABB.
- Store byte at 0x101 with data 0x12345677 -> `o_wb_sel` 0010, `o_mem_wb_data` 0x77777777. Store half at 0x102 with 0x0000BEEF -> sel 1100, data 0xBEEFBEEF. Store word at 0x104 -> sel 1111.
- Hold `i_wb_ack` low and issue 2 loads -> `o_wb_stall` = 1 and `o_wb_stb` = 0 on the third. Acks then return the two results in order with their own extensions: lb 0x103 -> 0xFFFFFF88, then lhu 0x100 -> 0x0000AABB.
- Drive `i_wb_stall` = 1 -> `o_wb_stall` = 1 and no push. Back-to-back accept plus ack every cycle -> count steady at 1.
- Assert `i_reset` with 2 entries pending -> count 0 and `o_wb_stall` = 0 immediately (asynchronous). The first post-reset load decodes correctly.

Source files
------------

// File: rtl/cpu_mem_ctrl_if.sv
// rtl/cpu_mem_ctrl_if.sv - CPU-side and memory-side bus signals of the sub-word load/store adapter
//
// CPU side : i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_sel -> o_wb_data, o_wb_ack, o_wb_stall
// Mem side : o_wb_stb, o_wb_we, o_wb_addr, o_mem_wb_data, o_wb_sel -> i_mem_wb_data, i_wb_ack, i_wb_stall
// slave modport is the adapter's view; master modport is the surrounding system's view.
interface cpu_mem_ctrl_if;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [2:0]  i_sel;
  logic [31:0] o_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;

  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_mem_wb_data;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_mem_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;

  modport slave (
    input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_sel,
    output o_wb_data, o_wb_ack, o_wb_stall,
    output o_wb_stb, o_wb_we, o_wb_addr, o_mem_wb_data, o_wb_sel,
    input  i_mem_wb_data, i_wb_ack, i_wb_stall
  );

  modport master (
    output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_sel,
    input  o_wb_data, o_wb_ack, o_wb_stall,
    input  o_wb_stb, o_wb_we, o_wb_addr, o_mem_wb_data, o_wb_sel,
    output i_mem_wb_data, i_wb_ack, i_wb_stall
  );
endinterface

// File: rtl/cpu_mem_ctrl.sv
// rtl/cpu_mem_ctrl.sv - byte/half/word load-store adapter between CPU bus and word-wide BRAM
//
// i_clk   : system clock, rising edge
// i_reset : asynchronous active-high reset
// bus     : cpu_mem_ctrl_if.slave, CPU request/response and memory request/response signals
// Requests and responses pass through combinationally; a 2-entry FIFO remembers the
// {code, offset} of each accepted request so the returning word can be lane-extracted.
module cpu_mem_ctrl (
  input  logic           i_clk,
  input  logic           i_reset,
  cpu_mem_ctrl_if.slave  bus
);

  logic [4:0]  fifo_mem [0:1];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [4:0]  head;
  logic [2:0]  head_code;
  logic [1:0]  head_off;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] rdata;
  logic [3:0]  sel_out;
  logic [31:0] wdata_out;

  // Full is judged on the registered count only, so a same-cycle pop never
  // frees a slot for the request presented in that cycle.
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign push  = bus.i_wb_stb & ~bus.o_wb_stall;
  assign pop   = bus.i_wb_ack & ~empty;

  assign bus.o_wb_stall    = bus.i_wb_stall | full;
  assign bus.o_wb_stb      = bus.i_wb_stb & ~full;
  assign bus.o_wb_we       = bus.i_wb_we;
  assign bus.o_wb_addr     = {bus.i_wb_addr[31:2], 2'b00};
  assign bus.o_wb_sel      = sel_out;
  assign bus.o_mem_wb_data = wdata_out;
  assign bus.o_wb_ack      = bus.i_wb_ack;
  assign bus.o_wb_data     = rdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= 5'd0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {bus.i_sel, bus.i_wb_addr[1:0]};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Request lane steering; unlisted codes fall through to word access.
  always_comb begin
    sel_out   = 4'b1111;
    wdata_out = bus.i_wb_data;
    case (bus.i_sel)
      3'b000, 3'b100: begin
        sel_out   = 4'b0001 << bus.i_wb_addr[1:0];
        wdata_out = {4{bus.i_wb_data[7:0]}};
      end
      3'b001, 3'b101: begin
        sel_out   = bus.i_wb_addr[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{bus.i_wb_data[15:0]}};
      end
      default: ;
    endcase
  end

  // A spurious ack (nothing tracked) is decoded as a plain word read.
  assign head      = empty ? 5'b010_00 : fifo_mem[rd_ptr];
  assign head_code = head[4:2];
  assign head_off  = head[1:0];

  always_comb begin
    shamt = 5'd0;
    case (head_code)
      3'b000, 3'b100: shamt = {head_off, 3'b000};
      3'b001, 3'b101: shamt = {head_off[1], 4'b0000};
      default:        shamt = 5'd0;
    endcase
  end

  assign shifted = bus.i_mem_wb_data >> shamt;

  always_comb begin
    rdata = bus.i_mem_wb_data;
    case (head_code)
      3'b000:  rdata = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  rdata = {24'd0, shifted[7:0]};
      3'b001:  rdata = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  rdata = {16'd0, shifted[15:0]};
      default: rdata = bus.i_mem_wb_data;
    endcase
  end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb/tb_cpu_mem_ctrl.sv - scoreboard testbench for cpu_mem_ctrl
module tb_cpu_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_ctrl_if bus ();

  cpu_mem_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] pend[$];
  bit          hold_ack = 1'b0;
  logic [29:0] wa;
  logic [31:0] tmp;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Memory model: accepts when o_wb_stb & !i_wb_stall, answers in order one cycle later
  // unless hold_ack is set.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (bus.i_wb_ack && pend.size() > 0) void'(pend.pop_front());
      if (bus.o_wb_stb && !bus.i_wb_stall) begin
        wa = bus.o_wb_addr[31:2];
        if (!mem.exists(wa)) mem[wa] = 32'h0;
        if (bus.o_wb_we) begin
          tmp = mem[wa];
          for (int b = 0; b < 4; b++)
            if (bus.o_wb_sel[b]) tmp[8*b +: 8] = bus.o_mem_wb_data[8*b +: 8];
          mem[wa] = tmp;
          pend.push_back(32'h0);
        end else begin
          pend.push_back(mem[wa]);
        end
      end
    end
    #1;
    bus.i_wb_ack      = (pend.size() > 0) && !hold_ack && !rst;
    bus.i_mem_wb_data = (pend.size() > 0) ? pend[0] : 32'h0;
  end

  // Response monitor
  always @(posedge clk) begin
    #4;
    if (bus.o_wb_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack (data 0x%08h)", bus.o_wb_data);
      end else begin
        e = sb.pop_front();
        if (e.chk) check({e.name, " rdata"}, bus.o_wb_data, e.data);
      end
    end
  end

  task automatic issue(string name, bit we, logic [2:0] code, logic [31:0] addr,
                       logic [31:0] wdata, logic [3:0] exp_sel, logic [31:0] exp_wdata,
                       bit exp_stall, bit exp_stb, bit chk_rd, logic [31:0] exp_rd);
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_sel     = code;
    bus.i_wb_addr = addr;
    bus.i_wb_data = wdata;
    #2;
    check({name, " stall"}, {31'd0, bus.o_wb_stall}, {31'd0, exp_stall});
    check({name, " stb"},   {31'd0, bus.o_wb_stb},   {31'd0, exp_stb});
    check({name, " sel"},   {28'd0, bus.o_wb_sel},   {28'd0, exp_sel});
    check({name, " addr"},  bus.o_wb_addr, {addr[31:2], 2'b00});
    if (we) check({name, " wdata"}, bus.o_mem_wb_data, exp_wdata);
    if (!exp_stall) sb.push_back('{chk_rd, exp_rd, name});
    @(posedge clk);
    #2;
    bus.i_wb_stb = 1'b0;
  endtask

  task automatic ld(string name, logic [2:0] code, logic [31:0] addr,
                    logic [3:0] exp_sel, logic [31:0] exp_rd);
    issue(name, 1'b0, code, addr, 32'h0, exp_sel, 32'h0, 1'b0, 1'b1, 1'b1, exp_rd);
  endtask

  task automatic st(string name, logic [2:0] code, logic [31:0] addr, logic [31:0] wdata,
                    logic [3:0] exp_sel, logic [31:0] exp_wdata);
    issue(name, 1'b1, code, addr, wdata, exp_sel, exp_wdata, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic idle(int n);
    bus.i_wb_stb = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_wb_stb      = 1'b0;
    bus.i_wb_we       = 1'b0;
    bus.i_wb_addr     = 32'h0;
    bus.i_wb_data     = 32'h0;
    bus.i_sel         = 3'b000;
    bus.i_wb_ack      = 1'b0;
    bus.i_wb_stall    = 1'b0;
    bus.i_mem_wb_data = 32'h0;
    mem[30'h40]       = 32'h8899AABB;

    #3;
    check("rst stall", {31'd0, bus.o_wb_stall}, 32'd0);
    check("rst stb",   {31'd0, bus.o_wb_stb},   32'd0);
    check("rst ack",   {31'd0, bus.o_wb_ack},   32'd0);
    check("rst addr",  bus.o_wb_addr, 32'h0);
    check("rst sel",   {28'd0, bus.o_wb_sel}, 32'h1);
    check("rst rdata", bus.o_wb_data, 32'h0);

    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);

    // Loads from 0x8899AABB at 0x100, back-to-back
    ld("lb_103",  3'b000, 32'h103, 4'b1000, 32'hFFFFFF88);
    ld("lbu_103", 3'b100, 32'h103, 4'b1000, 32'h00000088);
    ld("lh_102",  3'b001, 32'h102, 4'b1100, 32'hFFFF8899);
    ld("lhu_100", 3'b101, 32'h100, 4'b0011, 32'h0000AABB);
    ld("lw_100",  3'b010, 32'h100, 4'b1111, 32'h8899AABB);
    ld("lb_101",  3'b000, 32'h101, 4'b0010, 32'hFFFFFFAA);
    ld("lbu_102", 3'b100, 32'h102, 4'b0100, 32'h00000099);

    // Stores and read-back
    st("sb_101",  3'b000, 32'h101, 32'h12345677, 4'b0010, 32'h77777777);
    st("sh_102",  3'b001, 32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    st("sw_104",  3'b010, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    ld("lw_104",  3'b010, 32'h104, 4'b1111, 32'hCAFEF00D);
    ld("lh_101",  3'b001, 32'h101, 4'b0011, 32'h000077BB);
    ld("lb_103b", 3'b000, 32'h103, 4'b1000, 32'hFFFFFFBE);
    ld("l011",    3'b011, 32'h102, 4'b1111, 32'hBEEF77BB);
    st("sbu_100", 3'b100, 32'h100, 32'hFFFFFF55, 4'b0001, 32'h55555555);
    ld("lbu_100", 3'b100, 32'h100, 4'b0001, 32'h00000055);
    st("shu_100", 3'b101, 32'h100, 32'h1234A5A5, 4'b0011, 32'hA5A5A5A5);
    ld("lh_100",  3'b001, 32'h100, 4'b0011, 32'hFFFFA5A5);
    st("sw_100",  3'b010, 32'h100, 32'h8899AABB, 4'b1111, 32'h8899AABB);
    idle(3);

    // Two outstanding loads fill the tracker; the third is held off
    hold_ack = 1'b1;
    idle(1);
    ld("q_lb_103",  3'b000, 32'h103, 4'b1000, 32'hFFFFFF88);
    ld("q_lhu_100", 3'b101, 32'h100, 4'b0011, 32'h0000AABB);
    issue("q_full", 1'b0, 3'b010, 32'h100, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    hold_ack = 1'b0;
    idle(4);

    // Memory-side stall: passed through, nothing tracked
    bus.i_wb_stall = 1'b1;
    issue("mstall", 1'b0, 3'b010, 32'h100, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    bus.i_wb_stall = 1'b0;
    idle(3);

    // Asynchronous reset with two requests pending
    hold_ack = 1'b1;
    idle(1);
    ld("r_lb_103", 3'b000, 32'h103, 4'b1000, 32'hFFFFFF88);
    ld("r_lw_100", 3'b010, 32'h100, 4'b1111, 32'h8899AABB);
    check("full_before_reset", {31'd0, bus.o_wb_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("stall_in_reset", {31'd0, bus.o_wb_stall}, 32'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst      = 1'b0;
    hold_ack = 1'b0;
    idle(1);
    ld("post_rst_lb", 3'b000, 32'h103, 4'b1000, 32'hFFFFFF88);
    idle(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #5;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
